axil_fifos_rx_port: RTL and testbench



---
 rtl/axil_fifos_rx_pkg.sv | 23 ++
 rtl/axil_fifos_rx_decode.sv | 30 +++
 rtl/axil_fifos_rx_port.sv | 133 +++++++++++++
 tb/tb_axil_fifos_rx_port.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/axil_fifos_rx_pkg.sv
// Shared constants and types for the AXI-Lite receive-FIFO read port.
// Register offsets within a slot window, response codes, FSM states and the out-of-range filler word.
package axil_fifos_rx_pkg;

   localparam logic [7:0]  ISR_OFFSET  = 8'h00;
   localparam logic [7:0]  TDFV_OFFSET = 8'h0C;
   localparam logic [7:0]  RDFO_OFFSET = 8'h1C;
   localparam logic [7:0]  RDFD_OFFSET = 8'h20;
   localparam logic [7:0]  RLR_OFFSET  = 8'h24;
   localparam logic [31:0] SLOT_STRIDE = 32'h100;

   localparam logic [1:0]  RRESP_OKAY   = 2'b00;
   localparam logic [1:0]  RRESP_DECERR = 2'b11;

   localparam logic [31:0] FILLER_WORD  = 32'hBEEF_DEAD;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_RESP
   } rx_state_e;

endpackage

// File: rtl/axil_fifos_rx_decode.sv
// Combinational address decode: region hit, ROM window, slot index and data-pop offset.
module axil_fifos_rx_decode
   import axil_fifos_rx_pkg::*;
#(
   parameter int          num_fifos_p   = 2,
   parameter logic [31:0] base_addr_p   = 32'h0,
   parameter int          index_width_p = 4
) (
   input  logic [31:0]              addr,
   output logic                     in_range,
   output logic                     is_rom,
   output logic [index_width_p-1:0] slot_idx,
   output logic                     is_rdfd
);

   localparam logic [32:0] region_bytes_lp = 33'd1 << (index_width_p + 8);
   localparam logic [31:0] num_fifos_lp    = num_fifos_p;

   logic [31:0] off;

   // The 33-bit compare keeps a region ending exactly at 2^32 from wrapping.
   always_comb begin
      off      = addr - base_addr_p;
      in_range = (addr >= base_addr_p) && ({1'b0, off} < region_bytes_lp);
      slot_idx = off[8 +: index_width_p];
      is_rom   = (32'(slot_idx) >= num_fifos_lp);
      is_rdfd  = (off[7:0] == RDFD_OFFSET);
   end

endmodule

// File: rtl/axil_fifos_rx_port.sv
// AXI-Lite read slave exposing per-slot rx FIFO pops, status registers and a ROM window.
// Define AXIL_FIFOS_RX_DECERR_EN to answer out-of-range reads with DECERR instead of the filler word.
module axil_fifos_rx_port
   import axil_fifos_rx_pkg::*;
#(
   parameter int          num_fifos_p   = 2,
   parameter logic [31:0] base_addr_p   = 32'h0,
   parameter int          index_width_p = 4,
   parameter int          data_width_p  = 32
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [31:0]                         araddr_i,
   input  logic                                arvalid_i,
   output logic                                arready_o,
   output logic [data_width_p-1:0]             rdata_o,
   output logic [1:0]                          rresp_o,
   output logic                                rvalid_o,
   input  logic                                rready_i,
   input  logic [num_fifos_p-1:0]              rx_v_i,
   input  logic [num_fifos_p*data_width_p-1:0] rx_data_i,
   output logic [num_fifos_p-1:0]              rx_ready_o,
   output logic [31:0]                         rd_addr_o,
   input  logic [num_fifos_p*data_width_p-1:0] mon_data_i,
   input  logic [data_width_p-1:0]             rom_data_i
);

   rx_state_e                 state_r, state_n;
   logic [31:0]               rd_addr_r;
   logic [data_width_p-1:0]   rdata_r;
   logic [1:0]                rresp_r;
   logic [data_width_p-1:0]   stale_r [num_fifos_p];

   logic                      dec_in_range;
   logic                      dec_is_rom;
   logic [index_width_p-1:0]  dec_slot_idx;
   logic                      dec_is_rdfd;

   logic [data_width_p-1:0]   fetch_data;
   logic [1:0]                fetch_resp;
   logic [num_fifos_p-1:0]    fetch_pop;

   axil_fifos_rx_decode #(
      .num_fifos_p   (num_fifos_p),
      .base_addr_p   (base_addr_p),
      .index_width_p (index_width_p)
   ) decode (
      .addr     (rd_addr_r),
      .in_range (dec_in_range),
      .is_rom   (dec_is_rom),
      .slot_idx (dec_slot_idx),
      .is_rdfd  (dec_is_rdfd)
   );

   // An empty FIFO replays the last word popped from that slot instead of stalling the host.
   always_comb begin
      fetch_data = '0;
      fetch_resp = RRESP_OKAY;
      fetch_pop  = '0;
      if (!dec_in_range) begin
`ifdef AXIL_FIFOS_RX_DECERR_EN
         fetch_resp = RRESP_DECERR;
         fetch_data = '0;
`else
         fetch_data = data_width_p'(FILLER_WORD);
`endif
      end else if (dec_is_rom) begin
         fetch_data = rom_data_i;
      end else begin
         for (int n = 0; n < num_fifos_p; n++) begin
            if (dec_slot_idx == index_width_p'(n)) begin
               if (dec_is_rdfd) begin
                  if (rx_v_i[n]) begin
                     fetch_data   = rx_data_i[n*data_width_p +: data_width_p];
                     fetch_pop[n] = 1'b1;
                  end else begin
                     fetch_data = stale_r[n];
                  end
               end else begin
                  fetch_data = mon_data_i[n*data_width_p +: data_width_p];
               end
            end
         end
      end
   end

   always_comb begin
      state_n    = state_r;
      arready_o  = 1'b0;
      rvalid_o   = 1'b0;
      rx_ready_o = '0;
      unique case (state_r)
         ST_IDLE: begin
            arready_o = !reset_i;
            if (arvalid_i) state_n = ST_FETCH;
         end
         ST_FETCH: begin
            rx_ready_o = reset_i ? '0 : fetch_pop;
            state_n    = ST_RESP;
         end
         ST_RESP: begin
            rvalid_o = 1'b1;
            if (rready_i) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r   <= ST_IDLE;
         rd_addr_r <= '0;
         rdata_r   <= '0;
         rresp_r   <= RRESP_OKAY;
         for (int n = 0; n < num_fifos_p; n++) stale_r[n] <= '0;
      end else begin
         state_r <= state_n;
         if (state_r == ST_IDLE && arvalid_i) rd_addr_r <= araddr_i;
         if (state_r == ST_FETCH) begin
            rdata_r <= fetch_data;
            rresp_r <= fetch_resp;
            for (int n = 0; n < num_fifos_p; n++) begin
               if (fetch_pop[n]) stale_r[n] <= rx_data_i[n*data_width_p +: data_width_p];
            end
         end
      end
   end

   assign rdata_o   = rdata_r;
   assign rresp_o   = rresp_r;
   assign rd_addr_o = rd_addr_r;

endmodule

// File: tb/tb_axil_fifos_rx_port.sv
// Directed, table-driven bench for axil_fifos_rx_port (2 slots, base 0, 4 index bits).
// Expectations follow AXIL_FIFOS_RX_DECERR_EN when it is defined for the build.
module tb_axil_fifos_rx_port;

   logic        clk_i;
   logic        reset_i;
   logic [31:0] araddr_i;
   logic        arvalid_i;
   logic        arready_o;
   logic [31:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rvalid_o;
   logic        rready_i;
   logic [1:0]  rx_v_i;
   logic [63:0] rx_data_i;
   logic [1:0]  rx_ready_o;
   logic [31:0] rd_addr_o;
   logic [63:0] mon_data_i;
   logic [31:0] rom_data_i;

   int checks;
   int failures;

   localparam logic [31:0] MON0 = 32'h0000_0008;
   localparam logic [31:0] MON1 = 32'h0000_0011;
   localparam logic [31:0] ROM  = 32'hCAFE_0001;
`ifdef AXIL_FIFOS_RX_DECERR_EN
   localparam logic [31:0] OOR_DATA = 32'h0;
   localparam logic [1:0]  OOR_RESP = 2'b11;
`else
   localparam logic [31:0] OOR_DATA = 32'hBEEF_DEAD;
   localparam logic [1:0]  OOR_RESP = 2'b00;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  rx_v;
      logic [31:0] d0;
      logic [31:0] d1;
      int          hold;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      logic [1:0]  exp_yumi;
   } vec_t;

   vec_t vecs [13];

   axil_fifos_rx_port dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .araddr_i   (araddr_i),
      .arvalid_i  (arvalid_i),
      .arready_o  (arready_o),
      .rdata_o    (rdata_o),
      .rresp_o    (rresp_o),
      .rvalid_o   (rvalid_o),
      .rready_i   (rready_i),
      .rx_v_i     (rx_v_i),
      .rx_data_i  (rx_data_i),
      .rx_ready_o (rx_ready_o),
      .rd_addr_o  (rd_addr_o),
      .mon_data_i (mon_data_i),
      .rom_data_i (rom_data_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // One full read: AR handshake, FETCH, RESP held for 'hold' cycles, then the R handshake.
   task automatic applyStimulus(input int v);
      int cnt0;
      int cnt1;
      cnt0 = 0;
      cnt1 = 0;
      @(negedge clk_i);
      araddr_i  = vecs[v].addr;
      arvalid_i = 1'b1;
      rx_v_i    = vecs[v].rx_v;
      rx_data_i = {vecs[v].d1, vecs[v].d0};
      checkOutput($sformatf("v%0d_arready_idle", v), arready_o, 1);
      @(negedge clk_i);
      arvalid_i = 1'b0;
      araddr_i  = 32'hDEAD_0000;
      checkOutput($sformatf("v%0d_rd_addr", v), rd_addr_o, vecs[v].addr);
      checkOutput($sformatf("v%0d_rvalid_fetch", v), rvalid_o, 0);
      checkOutput($sformatf("v%0d_arready_fetch", v), arready_o, 0);
      cnt0 += rx_ready_o[0];
      cnt1 += rx_ready_o[1];
      @(negedge clk_i);
      checkOutput($sformatf("v%0d_rvalid_resp", v), rvalid_o, 1);
      checkOutput($sformatf("v%0d_rdata", v), rdata_o, vecs[v].exp_data);
      checkOutput($sformatf("v%0d_rresp", v), rresp_o, vecs[v].exp_resp);
      cnt0 += rx_ready_o[0];
      cnt1 += rx_ready_o[1];
      for (int h = 0; h < vecs[v].hold; h++) begin
         @(negedge clk_i);
         checkOutput($sformatf("v%0d_hold%0d_rdata", v, h), rdata_o, vecs[v].exp_data);
         checkOutput($sformatf("v%0d_hold%0d_rvalid", v, h), rvalid_o, 1);
         checkOutput($sformatf("v%0d_hold%0d_arready", v, h), arready_o, 0);
         cnt0 += rx_ready_o[0];
         cnt1 += rx_ready_o[1];
      end
      rready_i = 1'b1;
      @(negedge clk_i);
      rready_i = 1'b0;
      cnt0 += rx_ready_o[0];
      cnt1 += rx_ready_o[1];
      checkOutput($sformatf("v%0d_rvalid_done", v), rvalid_o, 0);
      checkOutput($sformatf("v%0d_arready_done", v), arready_o, 1);
      checkOutput($sformatf("v%0d_rd_addr_held", v), rd_addr_o, vecs[v].addr);
      checkOutput($sformatf("v%0d_yumi0_count", v), cnt0, vecs[v].exp_yumi[0]);
      checkOutput($sformatf("v%0d_yumi1_count", v), cnt1, vecs[v].exp_yumi[1]);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset_i    = 1'b1;
      araddr_i   = '0;
      arvalid_i  = 1'b0;
      rready_i   = 1'b0;
      rx_v_i     = '0;
      rx_data_i  = '0;
      mon_data_i = {MON1, MON0};
      rom_data_i = ROM;

      //        addr          rx_v   d0             d1             hold exp_data       resp   yumi
      vecs[0]  = '{32'h0000_0020, 2'b01, 32'h1234_5678, 32'hAAAA_0001, 0, 32'h1234_5678, 2'b00, 2'b01};
      vecs[1]  = '{32'h0000_0120, 2'b00, 32'h0,         32'hAAAA_0002, 0, 32'h0,         2'b00, 2'b00};
      vecs[2]  = '{32'h0000_001C, 2'b11, 32'h1111_1111, 32'h2222_2222, 0, MON0,          2'b00, 2'b00};
      vecs[3]  = '{32'h0000_0300, 2'b11, 32'h1111_1111, 32'h2222_2222, 0, ROM,           2'b00, 2'b00};
      vecs[4]  = '{32'h0000_1000, 2'b11, 32'h1111_1111, 32'h2222_2222, 0, OOR_DATA,      OOR_RESP, 2'b00};
      vecs[5]  = '{32'h0000_0120, 2'b10, 32'h3333_3333, 32'h5555_AAAA, 0, 32'h5555_AAAA, 2'b00, 2'b10};
      vecs[6]  = '{32'h0000_0120, 2'b00, 32'h3333_3333, 32'h6666_6666, 0, 32'h5555_AAAA, 2'b00, 2'b00};
      vecs[7]  = '{32'h0000_0020, 2'b00, 32'h4444_4444, 32'h6666_6666, 0, 32'h1234_5678, 2'b00, 2'b00};
      vecs[8]  = '{32'h0000_0124, 2'b11, 32'h4444_4444, 32'h6666_6666, 0, MON1,          2'b00, 2'b00};
      vecs[9]  = '{32'h0000_0220, 2'b11, 32'h4444_4444, 32'h6666_6666, 0, ROM,           2'b00, 2'b00};
      vecs[10] = '{32'h0000_0FFC, 2'b11, 32'h4444_4444, 32'h6666_6666, 0, ROM,           2'b00, 2'b00};
      vecs[11] = '{32'h0000_0020, 2'b11, 32'h0BAD_F00D, 32'h7777_7777, 5, 32'h0BAD_F00D, 2'b00, 2'b01};
      vecs[12] = '{32'h0000_0020, 2'b00, 32'h9999_9999, 32'h7777_7777, 0, 32'h0,         2'b00, 2'b00};

      repeat (3) @(negedge clk_i);
      checkOutput("reset_rvalid", rvalid_o, 0);
      checkOutput("reset_rdata", rdata_o, 0);
      checkOutput("reset_rresp", rresp_o, 0);
      checkOutput("reset_rd_addr", rd_addr_o, 0);
      checkOutput("reset_rx_ready", rx_ready_o, 0);
      reset_i = 1'b0;
      @(negedge clk_i);
      checkOutput("post_reset_arready", arready_o, 1);

      for (int v = 0; v < 12; v++) applyStimulus(v);

      // Reset during FETCH must suppress the pop and clear the stale words.
      @(negedge clk_i);
      araddr_i  = 32'h0000_0020;
      arvalid_i = 1'b1;
      rx_v_i    = 2'b01;
      rx_data_i = {32'h0, 32'h7777_0000};
      @(negedge clk_i);
      arvalid_i = 1'b0;
      reset_i   = 1'b1;
      #1;
      checkOutput("midreset_rx_ready", rx_ready_o, 0);
      @(negedge clk_i);
      checkOutput("midreset_rvalid", rvalid_o, 0);
      checkOutput("midreset_rx_ready_after", rx_ready_o, 0);
      checkOutput("midreset_rd_addr", rd_addr_o, 0);
      reset_i = 1'b0;
      @(negedge clk_i);
      checkOutput("midreset_arready", arready_o, 1);
      checkOutput("midreset_rvalid_idle", rvalid_o, 0);
      applyStimulus(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
